instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 28 ++
 rtl/instr_fetch.sv | 112 +++++++++++
 tb/tb_instr_fetch.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, execute-stage redirect,
// and the decode-facing instruction buffer head.
interface instr_fetch_if;
    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic        imem_req_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] Instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        misalign;

    modport master (
        output imem_req_valid, imem_addr, Instr, instr_pc, instr_valid, misalign,
        input  imem_req_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, Instr, instr_pc, instr_valid, misalign,
        output imem_req_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one request in flight, DEPTH-entry {instr, pc} buffer toward decode.
// Latency: head valid the cycle after the memory response; peak one instruction per 2 cycles.
// Backpressure: instr_ready low fills the buffer, then imem_req_valid stays low until space frees.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    localparam int              PW   = (DEPTH == 4) ? 2 : 1;
    localparam int              CW   = PW + 1;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    generate
        if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
            $error("instr_fetch: DEPTH must be 2 or 4");
        end
    endgenerate

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t          buf_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;

    // PCs are word aligned, so only bits [31:2] are stored.
    logic [29:0]     pc_q;
    logic [29:0]     inflight_pc_q;
    logic            outstanding_q;
    logic            drop_q;
    logic            misalign_q;

    logic            req_vld;
    logic            accept;
    logic            resp;
    logic            push;
    logic            pop;
    logic            head_vld;

    assign head_vld = (count_q != '0);
    assign req_vld  = ~rst & ~bus.redirect_valid & ~outstanding_q & (count_q < FULL);
    assign accept   = req_vld & bus.imem_req_ready;
    assign resp     = bus.imem_rvalid & outstanding_q;
    // Redirect outranks both response and pop: neither touches the buffer that cycle.
    assign push     = resp & ~drop_q & ~bus.redirect_valid;
    assign pop      = head_vld & bus.instr_ready & ~bus.redirect_valid;

    assign bus.imem_req_valid = req_vld;
    assign bus.imem_addr      = {pc_q, 2'b00};
    assign bus.instr_valid    = head_vld & ~rst;
    assign bus.Instr          = buf_q[rd_ptr_q].instr;
    assign bus.instr_pc       = buf_q[rd_ptr_q].pc;
    assign bus.misalign       = misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC[31:2];
            inflight_pc_q <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            misalign_q    <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            misalign_q <= bus.redirect_valid & (|bus.redirect_pc[1:0]);
            if (bus.redirect_valid) begin
                pc_q     <= bus.redirect_pc[31:2];
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                // An in-flight request not answered this cycle must be discarded later.
                outstanding_q <= outstanding_q & ~bus.imem_rvalid;
                drop_q        <= outstanding_q & ~bus.imem_rvalid;
            end else begin
                if (accept) begin
                    pc_q          <= pc_q + 30'd1;
                    inflight_pc_q <= pc_q;
                    outstanding_q <= 1'b1;
                end else if (resp) begin
                    outstanding_q <= 1'b0;
                    drop_q        <= 1'b0;
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= '{instr: bus.imem_rdata, pc: {inflight_pc_q, 2'b00}};
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run checked against a
// sequential-fetch model (fetches and consumes walk PC+4 from the last redirect target).
module tb_instr_fetch;

    logic clk;
    logic rst;

    instr_fetch_if bus ();
    instr_fetch_if i2 ();

    instr_fetch #(.RESET_PC(32'h00000000), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    instr_fetch #(.RESET_PC(32'hFFFFFFFC), .DEPTH(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (i2)
    );

    int n_total = 0;
    int n_pass  = 0;

    // memory responder state (mirrors what the bench itself has issued)
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;

    // values sampled inside each tick, before the clock edge
    logic        s_req, s_acc, s_iv, s_pop, s_mis;
    logic [31:0] s_addr, s_ipc, s_instr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    task automatic idle_inputs();
        bus.imem_req_ready = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b0;
        i2.imem_req_ready  = 1'b0;
        i2.imem_rvalid     = 1'b0;
        i2.imem_rdata      = 32'h0;
        i2.redirect_valid  = 1'b0;
        i2.redirect_pc     = 32'h0;
        i2.instr_ready     = 1'b0;
    endtask

    // Leaves the bench at 1 time unit after an edge, reset just released.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        pend = 1'b0;
    endtask

    // One cycle on the main DUT: drive, sample, advance responder, cross the edge.
    task automatic tick(input logic rdy, input int lat, input logic ir,
                        input logic rv, input logic [31:0] rpc, input logic sp);
        logic rsp;
        rsp = pend && (pend_cnt == 0);
        bus.imem_req_ready = rdy;
        bus.instr_ready    = ir;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.imem_rvalid    = rsp | (sp & ~pend);
        bus.imem_rdata     = rsp ? mem(pend_addr) : (32'hBAD00000 | $urandom_range(0, 65535));
        #1;
        s_req   = bus.imem_req_valid;
        s_addr  = bus.imem_addr;
        s_iv    = bus.instr_valid;
        s_ipc   = bus.instr_pc;
        s_instr = bus.Instr;
        s_mis   = bus.misalign;
        s_pop   = s_iv & ir & ~rv;
        s_acc   = s_req & rdy;
        if (rsp) pend = 1'b0;
        else if (pend) pend_cnt--;
        if (s_acc) begin
            pend      = 1'b1;
            pend_addr = s_addr;
            pend_cnt  = lat - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #2;
            n_total++; if (bus.imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", bus.imem_req_valid); else n_pass++;
            n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL rst_instr_valid: got %b want 0", bus.instr_valid); else n_pass++;
            n_total++; if (bus.misalign !== 1'b0) $display("FAIL rst_misalign: got %b want 0", bus.misalign); else n_pass++;
            n_total++; if (i2.imem_req_valid !== 1'b0) $display("FAIL rst_req_valid2: got %b want 0", i2.imem_req_valid); else n_pass++;
        end
        rst = 1'b0;
        #1;
        n_total++; if (bus.imem_req_valid !== 1'b1) $display("FAIL first_req: got %b want 1", bus.imem_req_valid); else n_pass++;
        n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL first_addr: got %h want 00000000", bus.imem_addr); else n_pass++;
        n_total++; if (i2.imem_addr !== 32'hFFFFFFFC) $display("FAIL first_addr2: got %h want fffffffc", i2.imem_addr); else n_pass++;
        @(posedge clk);
        #1;
        pend = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] pcs[3];
        logic [31:0] ins[3];
        int          cyc[3];
        int          n = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            tick(1'b1, 1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (s_pop && n < 3) begin
                pcs[n] = s_ipc; ins[n] = s_instr; cyc[n] = c; n++;
            end
        end
        n_total++; if (n !== 3) $display("FAIL stream_count: got %0d want 3", n); else n_pass++;
        for (int k = 0; k < n; k++) begin
            n_total++; if (pcs[k] !== 32'(k * 4)) $display("FAIL stream_pc%0d: got %h want %h", k, pcs[k], 32'(k * 4)); else n_pass++;
            n_total++; if (ins[k] !== mem(32'(k * 4))) $display("FAIL stream_instr%0d: got %h want %h", k, ins[k], mem(32'(k * 4))); else n_pass++;
            if (k > 0) begin
                n_total++; if (cyc[k] - cyc[k-1] !== 2) $display("FAIL stream_gap%0d: got %0d want 2", k, cyc[k] - cyc[k-1]); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        int          acc = 0;
        int          n = 0;
        logic [31:0] pcs[3];
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick(1'b1, 1, 1'b0, 1'b0, 32'h0, 1'b0);
            if (s_acc) acc++;
        end
        tick(1'b1, 1, 1'b0, 1'b0, 32'h0, 1'b0);
        n_total++; if (acc !== 2) $display("FAIL bp_accepts: got %0d want 2", acc); else n_pass++;
        n_total++; if (s_req !== 1'b0) $display("FAIL bp_req_valid: got %b want 0", s_req); else n_pass++;
        n_total++; if (s_iv !== 1'b1) $display("FAIL bp_instr_valid: got %b want 1", s_iv); else n_pass++;
        n_total++; if (s_ipc !== 32'h0) $display("FAIL bp_head_pc: got %h want 00000000", s_ipc); else n_pass++;
        for (int c = 0; c < 12 && n < 3; c++) begin
            tick(1'b1, 1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (s_pop) begin pcs[n] = s_ipc; n++; end
        end
        n_total++; if (n !== 3) $display("FAIL bp_drain_count: got %0d want 3", n); else n_pass++;
        for (int k = 0; k < n; k++) begin
            n_total++; if (pcs[k] !== 32'(k * 4)) $display("FAIL bp_drain_pc%0d: got %h want %h", k, pcs[k], 32'(k * 4)); else n_pass++;
        end
    endtask

    task automatic test_redirect_drop();
        logic        found = 1'b0;
        logic        got_fetch = 1'b0;
        logic        got_pop = 1'b0;
        logic [31:0] first_fetch = 32'hFFFFFFFF;
        logic [31:0] first_pc = 32'hFFFFFFFF;
        logic [31:0] first_ins = 32'h0;
        do_reset();
        for (int c = 0; c < 30 && !found; c++) begin
            tick(1'b1, 3, 1'b1, 1'b0, 32'h0, 1'b0);
            if (s_acc && s_addr == 32'h8) found = 1'b1;
        end
        n_total++; if (found !== 1'b1) $display("FAIL rd_issue8: got %b want 1", found); else n_pass++;
        tick(1'b1, 3, 1'b1, 1'b1, 32'h100, 1'b0);
        n_total++; if (s_req !== 1'b0) $display("FAIL rd_req_during_redirect: got %b want 0", s_req); else n_pass++;
        for (int c = 0; c < 30 && !got_pop; c++) begin
            tick(1'b1, 3, 1'b1, 1'b0, 32'h0, 1'b0);
            if (s_acc && !got_fetch) begin got_fetch = 1'b1; first_fetch = s_addr; end
            if (s_pop) begin got_pop = 1'b1; first_pc = s_ipc; first_ins = s_instr; end
        end
        n_total++; if (first_fetch !== 32'h100) $display("FAIL rd_first_fetch: got %h want 00000100", first_fetch); else n_pass++;
        n_total++; if (first_pc !== 32'h100) $display("FAIL rd_first_pc: got %h want 00000100", first_pc); else n_pass++;
        n_total++; if (first_ins !== mem(32'h100)) $display("FAIL rd_first_instr: got %h want %h", first_ins, mem(32'h100)); else n_pass++;
    endtask

    task automatic test_misalign();
        do_reset();
        tick(1'b1, 1, 1'b1, 1'b0, 32'h0, 1'b0);
        tick(1'b1, 1, 1'b1, 1'b1, 32'h203, 1'b0);
        n_total++; if (s_mis !== 1'b0) $display("FAIL mis_before: got %b want 0", s_mis); else n_pass++;
        tick(1'b1, 1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_total++; if (s_mis !== 1'b1) $display("FAIL mis_pulse: got %b want 1", s_mis); else n_pass++;
        n_total++; if (s_req !== 1'b1) $display("FAIL mis_req: got %b want 1", s_req); else n_pass++;
        n_total++; if (s_addr !== 32'h200) $display("FAIL mis_addr: got %h want 00000200", s_addr); else n_pass++;
        tick(1'b1, 1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_total++; if (s_mis !== 1'b0) $display("FAIL mis_after: got %b want 0", s_mis); else n_pass++;
        tick(1'b1, 1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_total++; if (s_iv !== 1'b1 || s_ipc !== 32'h200) $display("FAIL mis_head: got valid=%b pc=%h want valid=1 pc=00000200", s_iv, s_ipc); else n_pass++;
    endtask

    task automatic test_wrap_depth4();
        logic [31:0] addrs[6];
        logic [31:0] exp_a[4];
        logic        p2 = 1'b0;
        logic [31:0] a2 = 32'h0;
        int          n = 0;
        exp_a[0] = 32'hFFFFFFFC; exp_a[1] = 32'h0; exp_a[2] = 32'h4; exp_a[3] = 32'h8;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            i2.imem_req_ready = 1'b1;
            i2.instr_ready    = 1'b0;
            i2.imem_rvalid    = p2;
            i2.imem_rdata     = mem(a2);
            #1;
            if (p2) p2 = 1'b0;
            else if (i2.imem_req_valid) begin
                if (n < 6) addrs[n] = i2.imem_addr;
                n++;
                a2 = i2.imem_addr;
                p2 = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        i2.imem_rvalid = 1'b0;
        #1;
        n_total++; if (n !== 4) $display("FAIL wrap_fetch_count: got %0d want 4", n); else n_pass++;
        for (int k = 0; k < 4 && k < n; k++) begin
            n_total++; if (addrs[k] !== exp_a[k]) $display("FAIL wrap_addr%0d: got %h want %h", k, addrs[k], exp_a[k]); else n_pass++;
        end
        n_total++; if (i2.imem_req_valid !== 1'b0) $display("FAIL wrap_full_req: got %b want 0", i2.imem_req_valid); else n_pass++;
        n_total++; if (i2.instr_pc !== 32'hFFFFFFFC) $display("FAIL wrap_head_pc: got %h want fffffffc", i2.instr_pc); else n_pass++;
        n_total++; if (i2.Instr !== mem(32'hFFFFFFFC)) $display("FAIL wrap_head_instr: got %h want %h", i2.Instr, mem(32'hFFFFFFFC)); else n_pass++;
        i2.imem_req_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic found = 1'b0;
        do_reset();
        for (int c = 0; c < 5 && !found; c++) begin
            tick(1'b1, 50, 1'b0, 1'b0, 32'h0, 1'b0);
            if (s_acc) found = 1'b1;
        end
        n_total++; if (found !== 1'b1) $display("FAIL rm_issue: got %b want 1", found); else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        pend = 1'b0;
        tick(1'b0, 1, 1'b1, 1'b0, 32'h0, 1'b1);
        n_total++; if (s_req !== 1'b1 || s_addr !== 32'h0) $display("FAIL rm_refetch: got req=%b addr=%h want req=1 addr=00000000", s_req, s_addr); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 1, 1'b1, 1'b0, 32'h0, 1'b0);
            n_total++; if (s_iv !== 1'b0) $display("FAIL rm_no_push%0d: got %b want 0", c, s_iv); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] fetch_exp = 32'h0;
        logic [31:0] cons_exp  = 32'h0;
        logic        mis_exp   = 1'b0;
        logic        rdy, ir, rv, sp, pb;
        logic [31:0] rpc;
        int          lat;
        do_reset();
        for (int c = 0; c < 700; c++) begin
            rdy = ($urandom_range(0, 9) < 7);
            lat = $urandom_range(1, 4);
            ir  = ($urandom_range(0, 9) < 6);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = $urandom;
            sp  = ($urandom_range(0, 9) == 0);
            pb  = pend;
            tick(rdy, lat, ir, rv, rpc, sp);
            n_total++; if (s_mis !== mis_exp) $display("FAIL rnd_misalign c=%0d: got %b want %b", c, s_mis, mis_exp); else n_pass++;
            mis_exp = rv & (|rpc[1:0]);
            n_total++; if (s_req && (rv || pb)) $display("FAIL rnd_req_gate c=%0d: got req=1 want 0 (redirect=%b busy=%b)", c, rv, pb); else n_pass++;
            if (s_acc) begin
                n_total++; if (s_addr !== fetch_exp) $display("FAIL rnd_fetch c=%0d: got %h want %h", c, s_addr, fetch_exp); else n_pass++;
                fetch_exp = fetch_exp + 32'd4;
            end
            if (s_pop) begin
                n_total++; if (s_ipc !== cons_exp || s_instr !== mem(cons_exp)) $display("FAIL rnd_pop c=%0d: got pc=%h instr=%h want pc=%h instr=%h", c, s_ipc, s_instr, cons_exp, mem(cons_exp)); else n_pass++;
                cons_exp = cons_exp + 32'd4;
            end
            n_total++; if (((fetch_exp - cons_exp) >> 2) > 32'd2) $display("FAIL rnd_occupancy c=%0d: got %0d want <=2", c, (fetch_exp - cons_exp) >> 2); else n_pass++;
            if (rv) begin
                fetch_exp = {rpc[31:2], 2'b00};
                cons_exp  = {rpc[31:2], 2'b00};
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        pend = 1'b0;
        pend_cnt = 0;
        pend_addr = 32'h0;
        idle_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_misalign();
        test_wrap_depth4();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
